// File: rtl/sca_ch_enable_ctrl_if.sv
// Command/response bus of the SCA channel-enable controller.
// The master issues register commands; the slave returns one response per command.
interface sca_ch_enable_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_error;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/sca_ch_enable_ctrl.sv
// SCA channel-enable registers CRB/CRC/CRD driving ch_enable into the gating stage.
// Enables apply at once; disables wait for the channel to drain or for a timeout.
module sca_ch_enable_ctrl #(
  parameter int n_ch         = 22,
  parameter int SETTLE_CYC   = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  sca_ch_enable_ctrl_if.slave   bus,
  input  logic [n_ch-1:0]       ch_busy,
  output logic [n_ch-1:0]       ch_enable
);

  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, RESP} state_t;

  localparam logic [15:0] DRAIN_LAST  = 16'(BUSY_TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_ADDR    = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

  state_t          state_q, state_d;
  logic [n_ch-1:0] ch_enable_q, ch_enable_d;
  logic [n_ch-1:0] pending_q, pending_d;
  logic [15:0]     drain_cnt_q, drain_cnt_d;
  logic [7:0]      settle_cnt_q, settle_cnt_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      addr_q, addr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_error_q, rsp_error_d;

  logic [n_ch-1:0] wr_vec;
  logic [n_ch-1:0] turn_on;
  logic [n_ch-1:0] turn_off;
  logic [n_ch-1:0] drained;
  logic [n_ch-1:0] remaining;
  logic [23:0]     en_ext;
  logic [1:0]      rd_sel;
  logic [7:0]      rd_slice;

  // Candidate enable vector after a write: the addressed slice takes wdata,
  // channels of other registers keep their current value.
  for (genvar gi = 0; gi < n_ch; gi++) begin : g_wr
    assign wr_vec[gi] = (bus.cmd_addr == 2'(gi / 8)) ? bus.cmd_wdata[gi % 8]
                                                     : ch_enable_q[gi];
  end

  assign turn_on   = wr_vec & ~ch_enable_q;
  assign turn_off  = ch_enable_q & ~wr_vec;
  assign drained   = pending_q & ~ch_busy;
  assign remaining = pending_q & ch_busy;

  // Bits beyond n_ch read as zero through the zero extension.
  assign en_ext = 24'(ch_enable_q);
  assign rd_sel = (state_q == IDLE) ? bus.cmd_addr : addr_q;

  always_comb begin
    rd_slice = 8'h00;
    case (rd_sel)
      2'd0:    rd_slice = en_ext[7:0];
      2'd1:    rd_slice = en_ext[15:8];
      2'd2:    rd_slice = en_ext[23:16];
      default: rd_slice = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ch_enable_d  = ch_enable_q;
    pending_d    = pending_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;
    timeout_d    = timeout_q;
    addr_d       = addr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (bus.cmd_addr == 2'd3) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 8'h00;
            rsp_error_d = ERR_ADDR;
          end else if (!bus.cmd_write) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_slice;
            rsp_error_d = ERR_OK;
          end else begin
            addr_d      = bus.cmd_addr;
            timeout_d   = 1'b0;
            ch_enable_d = (ch_enable_q | turn_on) & ~(turn_off & ~ch_busy);
            pending_d   = turn_off & ch_busy;
            if (pending_d == '0) begin
              state_d      = SETTLE;
              settle_cnt_d = 8'd0;
            end else begin
              state_d     = DRAIN;
              drain_cnt_d = 16'd0;
            end
          end
        end
      end

      DRAIN: begin
        ch_enable_d  = ch_enable_q & ~drained;
        pending_d    = remaining;
        drain_cnt_d  = drain_cnt_q + 16'd1;
        settle_cnt_d = 8'd0;
        // A channel that drains on the timeout edge counts as drained.
        if (remaining == '0) begin
          state_d = SETTLE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          ch_enable_d = ch_enable_q & ~pending_q;
          pending_d   = '0;
          timeout_d   = 1'b1;
          state_d     = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_slice;
          rsp_error_d = timeout_q ? ERR_TIMEOUT : ERR_OK;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_enable_q  <= '0;
      pending_q    <= '0;
      drain_cnt_q  <= 16'd0;
      settle_cnt_q <= 8'd0;
      timeout_q    <= 1'b0;
      addr_q       <= 2'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      rsp_error_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      ch_enable_q  <= ch_enable_d;
      pending_q    <= pending_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      timeout_q    <= timeout_d;
      addr_q       <= addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) & ~reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign ch_enable     = ch_enable_q;

endmodule
